// File: rtl/fanout_share_scheduler.sv
// fanout_share_scheduler
//   Time-shares one buffered driver net among NUM_REQ requesters. A round-robin
//   arbiter hands out ownership for at most MAX_HOLD beats per grant. Accepted
//   beats travel a PIPE_STAGES-deep register chain that stands in for the
//   buffer stages in front of the loads, and leave with a one-hot group select.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req_valid    per-requester beat valid
//   req_data     per-requester payload, requester i at [i*DATA_W +: DATA_W]
//   req_ready    per-requester accept (combinational)
//   flush        stop accepting and drain the pipeline
//   out_valid    shared-net beat valid
//   out_data     shared-net payload (0 when out_valid=0)
//   out_sel      one-hot destination load group (0 when out_valid=0)
//   grant_id     current owner while a grant is active, else 0
//   busy         arbiter not idle or a beat still in flight
module fanout_share_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int PIPE_STAGES = 2,
    parameter int MAX_HOLD    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [NUM_REQ-1:0]         out_sel,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [PIPE_STAGES-1:0]              pv_q;
    logic [PIPE_STAGES-1:0][DATA_W-1:0]  pd_q;
    logic [PIPE_STAGES-1:0][NUM_REQ-1:0] ps_q;

    logic              accept;
    logic [DATA_W-1:0] acc_data;
    logic [NUM_REQ-1:0] acc_sel;
    logic [HOLD_W-1:0] hold_inc;

    // First asserted requester at or above ptr, wrapping. Scanning offsets from
    // high to low lets the smallest offset overwrite the others.
    function automatic logic [ID_W-1:0] rr_pick(input logic [ID_W-1:0]    ptr,
                                                input logic [NUM_REQ-1:0] v);
        logic [ID_W-1:0] pick;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (v[idx]) pick = ID_W'(idx);
        end
        return pick;
    endfunction

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        if (int'(id) == NUM_REQ - 1) return '0;
        return id + 1'b1;
    endfunction

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every register samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Next-state logic.
    // NOTE: every signal driven here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        accept     = 1'b0;
        hold_inc   = hold_cnt_q + 1'b1;
        acc_data   = req_data[int'(owner_q)*DATA_W +: DATA_W];
        acc_sel    = NUM_REQ'(1) << owner_q;

        unique case (state_q)
            IDLE: begin
                if (!flush && |req_valid) begin
                    owner_d    = rr_pick(rr_ptr_q, req_valid);
                    hold_cnt_d = '0;
                    state_d    = OWN;
                end
            end
            OWN: begin
                if (flush) begin
                    state_d  = DRAIN;
                    rr_ptr_d = next_ptr(owner_q);
                end else if (req_valid[owner_q]) begin
                    accept     = 1'b1;
                    hold_cnt_d = hold_inc;
                    if (hold_inc == HOLD_W'(MAX_HOLD)) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr(owner_q);
                    end
                end else begin
                    // Owner went quiet: release so the next requester gets a turn.
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr(owner_q);
                end
            end
            DRAIN: begin
                if (!(|pv_q) && !flush) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        req_ready = '0;
        if (state_q == OWN && !flush) req_ready[owner_q] = 1'b1;
        grant_id  = (state_q == OWN) ? owner_q : '0;
        busy      = (state_q != IDLE) || (|pv_q);
    end

    // Buffer-stage chain; shifts every cycle, loads never stall it.
    // NOTE: the stages are reset (not left as uninitialised storage) because a
    // reset must discard in-flight beats rather than let them reach the loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            pd_q <= '0;
            ps_q <= '0;
        end else begin
            // Payload and select are zeroed on empty slots so the output needs
            // no extra masking.
            pv_q[0] <= accept;
            pd_q[0] <= accept ? acc_data : '0;
            ps_q[0] <= accept ? acc_sel  : '0;
            for (int k = 1; k < PIPE_STAGES; k++) begin
                pv_q[k] <= pv_q[k-1];
                pd_q[k] <= pd_q[k-1];
                ps_q[k] <= ps_q[k-1];
            end
        end
    end

    assign out_valid = pv_q[PIPE_STAGES-1];
    assign out_data  = pd_q[PIPE_STAGES-1];
    assign out_sel   = ps_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_fanout_share_scheduler.sv
`timescale 1ns/1ps
// Testbench for fanout_share_scheduler: directed scenarios plus randomized
// traffic, checked against a behavioural model and an output scoreboard.
module tb_fanout_share_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int P  = 2;
    localparam int MH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            flush = 1'b0;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [N-1:0]    out_sel;
    logic [1:0]      grant_id;
    logic            busy;

    fanout_share_scheduler #(
        .NUM_REQ(N), .DATA_W(DW), .PIPE_STAGES(P), .MAX_HOLD(MH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .flush(flush), .out_valid(out_valid),
        .out_data(out_data), .out_sel(out_sel), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard of beats expected on the shared net, tagged with the cycle
    // they must be visible in.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic [N-1:0]  sel;
    } beat_t;
    beat_t sb[$];

    // Behavioural reference: who owns the net, where the round-robin pointer
    // sits, how many beats the owner has used, and when the last beat entered
    // the buffer chain (a beat occupies the chain for P cycles).
    int m_mode  = 0;    // 0 idle, 1 owned, 2 draining
    int m_owner = 0;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_last  = -100;

    always @(negedge clk) begin
        logic [N-1:0] e_ready;
        int           e_gid;
        bit           e_busy;
        bit           pipe_busy;
        bit           found;
        if (!rst_n) begin
            m_mode = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_last = -100;
            check("reset_ready", 32'(req_ready), 32'd0);
            check("reset_grant", 32'(grant_id), 32'd0);
            check("reset_busy", 32'(busy), 32'd0);
        end else begin
            e_ready   = '0;
            e_gid     = 0;
            pipe_busy = (m_last >= cyc - P);
            e_busy    = (m_mode != 0) || pipe_busy;
            if (m_mode == 1) begin
                e_gid = m_owner;
                if (!flush) e_ready[m_owner] = 1'b1;
            end
            check("req_ready", 32'(req_ready), 32'(e_ready));
            check("grant_id", 32'(grant_id), 32'(e_gid));
            check("busy", 32'(busy), 32'(e_busy));

            case (m_mode)
                0: if (!flush && req_valid != '0) begin
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        int r;
                        r = (m_ptr + k) % N;
                        if (!found && req_valid[r]) begin
                            found = 1'b1;
                            m_owner = r;
                        end
                    end
                    m_hold = 0;
                    m_mode = 1;
                end
                1: begin
                    if (flush) begin
                        m_mode = 2;
                        m_ptr  = (m_owner + 1) % N;
                    end else if (req_valid[m_owner]) begin
                        sb.push_back('{due: cyc + P,
                                       data: req_data[m_owner*DW +: DW],
                                       sel: N'(1) << m_owner});
                        m_last = cyc;
                        m_hold++;
                        if (m_hold == MH) begin
                            m_mode = 0;
                            m_ptr  = (m_owner + 1) % N;
                        end
                    end else begin
                        m_mode = 0;
                        m_ptr  = (m_owner + 1) % N;
                    end
                end
                default: if (!pipe_busy && !flush) m_mode = 0;
            endcase
        end
    end

    // Monitor: compares whatever the shared net shows against the scoreboard.
    always @(negedge clk) begin
        bit exp_v;
        if (!rst_n) begin
            check("reset_out_valid", 32'(out_valid), 32'd0);
        end else begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                check("beat_missing", 32'd0, 32'(sb[0].data));
                void'(sb.pop_front());
            end
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            check("out_valid", 32'(out_valid), 32'(exp_v));
            if (exp_v) begin
                check("out_data", 32'(out_data), 32'(sb[0].data));
                check("out_sel", 32'(out_sel), 32'(sb[0].sel));
                void'(sb.pop_front());
            end else begin
                check("idle_out_data", 32'(out_data), 32'd0);
                check("idle_out_sel", 32'(out_sel), 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Asynchronous reset between edges; outputs must clear with no clock edge.
    task automatic async_reset_pulse();
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_req_ready", 32'(req_ready), 32'd0);
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Single beat from requester 0: one IDLE cycle, one accept, then release.
        req_valid = 4'b0001;
        req_data[DW-1:0] = 8'hA5;
        tick(2);
        req_valid = '0;
        tick(6);

        // Hold limit: requester 0 keeps asking while requester 1 waits.
        req_valid = 4'b0011;
        for (int i = 0; i < 16; i++) begin
            req_data = $urandom;
            tick(1);
        end
        req_valid = '0;
        tick(6);

        // Flush on requester 2's second beat; requester 3 is next in line.
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 8'h11;
        tick(2);
        req_data[2*DW +: DW] = 8'h22;
        flush = 1'b1;
        req_valid = 4'b1101;
        tick(5);
        flush = 1'b0;
        tick(8);
        req_valid = '0;
        tick(6);

        // Async reset while requester 1 has beats in flight.
        req_valid = 4'b0010;
        req_data = $urandom;
        tick(4);
        async_reset_pulse();
        req_valid = '0;
        tick(6);

        // Wrap-around: requester 3 owns, then releases while 0 and 2 wait.
        req_valid = 4'b1000;
        tick(3);
        req_valid = 4'b0101;
        tick(8);
        req_valid = '0;
        tick(6);

        // Randomized traffic with sticky valids, occasional flush and reset.
        for (int i = 0; i < 4000; i++) begin
            for (int r = 0; r < N; r++)
                if ($urandom_range(3) == 0) req_valid[r] = ~req_valid[r];
            req_data = $urandom;
            if (flush) flush = ($urandom_range(1) == 0);
            else       flush = ($urandom_range(24) == 0);
            if ($urandom_range(799) == 0) async_reset_pulse();
            else tick(1);
        end

        req_valid = '0;
        flush = 1'b0;
        tick(12);
        check("drain_empty", 32'(sb.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
